instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle instruction sequencer controlling a shared instruction/data
//   memory. Walks IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB and back to
//   FETCH (or IDLE when run is low). The opcode class is latched in DECODE,
//   and all later decisions use only the latched class.
//
//   Optional feature (macro SEQ_MEM_TIMEOUT_EN):
//     When defined, a 4-bit wait counter watches memory requests. On the 16th
//     consecutive unacknowledged request cycle the FSM enters ERROR, which is
//     left only by reset. When undefined, the sequencer waits forever for
//     mem_ack and bus_error is tied low.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   run          in   fetch/execute enable (level)
//   opcode[5:0]  in   instruction-register opcode field, valid from DECODE
//   mem_ack      in   memory acknowledge, only looked at while mem_req=1
//   mem_req      out  memory request
//   mem_we       out  1 = write, 0 = read
//   mem_addr_sel out  0 = PC (fetch), 1 = ALU result (data)
//   ir_write     out  instruction-register load strobe (combinational)
//   pc_write     out  PC update strobe
//   reg_write    out  register-file write strobe
//   instr_done   out  one-cycle retire pulse
//   busy         out  high except in IDLE and ERROR
//   state[2:0]   out  encoded current state
//   bus_error    out  sticky memory-timeout flag
// ---------------------------------------------------------------------------
module instr_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       instr_done,
  output logic       busy,
  output logic [2:0] state,
  output logic       bus_error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_NOP    = 3'd0,
    C_ALU    = 3'd1,
    C_BRANCH = 3'd2,
    C_CALL   = 3'd3,
    C_LOAD   = 3'd4,
    C_STORE  = 3'd5
  } class_e;

  // Map a raw opcode onto its execution class; unknown opcodes behave as NOP.
  function automatic class_e decode_class(input logic [5:0] op);
    class_e c;
    case (op)
      6'b000001, 6'b000010, 6'b000011,
      6'b111100, 6'b111101: c = C_ALU;
      6'b000100, 6'b000101: c = C_BRANCH;
      6'b000110:            c = C_CALL;
      6'b111110:            c = C_LOAD;
      6'b111111:            c = C_STORE;
      default:              c = C_NOP;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  class_e class_q, class_d;

  logic mem_req_q,  mem_req_d;
  logic mem_we_q,   mem_we_d;
  logic addr_sel_q, addr_sel_d;
  logic pc_write_q, pc_write_d;
  logic reg_write_q, reg_write_d;
  logic done_q,     done_d;
  logic busy_q,     busy_d;

  logic timeout_s;

  // Next-state and latched-class logic.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_FETCH: begin
        if (mem_ack)        state_d = S_DECODE;
        else if (timeout_s) state_d = S_ERROR;
        else                state_d = S_FETCH;
      end
      S_DECODE: begin
        class_d = decode_class(opcode);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Only loads and stores need a data-memory phase.
        if ((class_q == C_LOAD) || (class_q == C_STORE)) state_d = S_MEM;
        else                                             state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ack)        state_d = S_WB;
        else if (timeout_s) state_d = S_ERROR;
        else                state_d = S_MEM;
      end
      S_WB: begin
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs, decoded from the upcoming state/class so the registered
  // copies line up with state_q in the following cycle.
  always_comb begin
    mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_we_d    = (state_d == S_MEM) && (class_d == C_STORE);
    addr_sel_d  = (state_d == S_MEM);
    pc_write_d  = (state_d == S_WB);
    done_d      = (state_d == S_WB);
    reg_write_d = (state_d == S_WB) &&
                  ((class_d == C_ALU) || (class_d == C_CALL) || (class_d == C_LOAD));
    busy_d      = (state_d != S_IDLE) && (state_d != S_ERROR);
  end

  // FSM state, latched class and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      class_q     <= C_NOP;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_sel_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      addr_sel_q  <= addr_sel_d;
      pc_write_q  <= pc_write_d;
      reg_write_q <= reg_write_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       bus_error_q;

  // On the 16th unacknowledged request cycle the counter already reads 15.
  assign timeout_s = (wait_cnt_q == 4'd15);

  // Count consecutive unacknowledged request cycles within one state.
  always_comb begin
    if (state_d != state_q)         wait_cnt_d = 4'd0;
    else if (mem_req_q && !mem_ack) wait_cnt_d = wait_cnt_q + 4'd1;
    else                            wait_cnt_d = 4'd0;
  end

  // Wait counter and sticky error flag (sticky because ERROR is absorbing).
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= 4'd0;
      bus_error_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= (state_d == S_ERROR);
    end
  end

  assign bus_error = bus_error_q;
`else
  assign timeout_s = 1'b0;
  assign bus_error = 1'b0;
`endif

  // Instruction register loads in the cycle the fetch is acknowledged.
  assign ir_write     = (state_q == S_FETCH) && mem_ack;

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr_sel = addr_sel_q;
  assign pc_write     = pc_write_q;
  assign reg_write    = reg_write_q;
  assign instr_done   = done_q;
  assign busy         = busy_q;
  assign state        = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for instr_sequencer. Each instruction is described at the
// instruction level (opcode, fetch wait cycles, memory wait cycles, run
// level after decode); the bench expands that into the expected per-cycle
// phase sequence, and a single compare process checks every output on every
// cycle. Literal latency / reg_write checks pin the expansion itself.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, mem_ack;
  logic [5:0] opcode;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
  logic       reg_write, instr_done, busy, bus_error;
  logic [2:0] state;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .instr_done(instr_done), .busy(busy), .state(state), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc_n    = 0;
  int          busy_cnt = 0;
  bit          reg_seen = 1'b0;
  bit          chk_en   = 1'b0;
  logic [11:0] exp_v;

  // Phases: 0 IDLE 1 FETCH 2 DECODE 3 EXEC 4 MEM 5 WB 6 ERROR
  // Classes: 0 NOP 1 ALU 2 BRANCH 3 CALL 4 LOAD 5 STORE
  function automatic int cls_of(input logic [5:0] op);
    case (op)
      6'b000001, 6'b000010, 6'b000011, 6'b111100, 6'b111101: return 1;
      6'b000100, 6'b000101: return 2;
      6'b000110:            return 3;
      6'b111110:            return 4;
      6'b111111:            return 5;
      default:              return 0;
    endcase
  endfunction

  // Expected outputs for a phase: {state, mem_req, mem_we, addr_sel,
  // ir_write, pc_write, reg_write, instr_done, busy, bus_error}
  function automatic logic [11:0] model(input int ph, input int cls, input bit ack);
    logic [2:0] s;
    bit fetch, mem, wb;
    s     = 3'(ph);
    fetch = (ph == 1);
    mem   = (ph == 4);
    wb    = (ph == 5);
    return {s, fetch | mem, mem & (cls == 5), mem, fetch & ack, wb,
            wb & ((cls == 1) | (cls == 3) | (cls == 4)), wb,
            (ph != 0) & (ph != 6), (ph == 6)};
  endfunction

  // Single compare process: sample on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [11:0] got;
      got = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
             reg_write, instr_done, busy, bus_error};
      n_checks++;
      if (got === exp_v) n_pass++;
      else $display("FAIL row cyc=%0d got=%b expected=%b", cyc_n, got, exp_v);
      if (busy === 1'b1) busy_cnt++;
      if (reg_write === 1'b1) reg_seen = 1'b1;
      cyc_n++;
    end
  end

  task automatic check_lit(input string name, input int got, input int expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, expv);
  endtask

  // Drive one cycle: inputs and the expected outputs for this cycle.
  task automatic cyc(input int ph, input int cls, input bit ack, input bit r);
    run     = r;
    mem_ack = ack;
    exp_v   = model(ph, cls, ack);
    @(posedge clk);
    #1;
  endtask

  // Expand one instruction into its phase sequence. Acks are also driven in
  // non-request phases to show they are ignored; the opcode is scrambled
  // after DECODE to show only the latched class is used.
  task automatic instr(input logic [5:0] op, input int wf, input int wm,
                       input bit rt, input int lat_exp);
    int c;
    c        = cls_of(op);
    busy_cnt = 0;
    opcode   = op;
    for (int i = 0; i <= wf; i++) cyc(1, c, (i == wf), 1'b1);
    cyc(2, c, 1'b1, 1'b1);
    opcode = op ^ 6'b111111;
    cyc(3, c, 1'b1, rt);
    if ((c == 4) || (c == 5))
      for (int i = 0; i <= wm; i++) cyc(4, c, (i == wm), rt);
    cyc(5, c, 1'b1, rt);
    check_lit("latency", busy_cnt, lat_exp);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; opcode = 6'b000000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    // Reset wins over run and mem_ack.
    cyc(0, 0, 1'b1, 1'b1);
    cyc(0, 0, 1'b1, 1'b1);
    rst = 1'b0;
    cyc(0, 0, 1'b0, 1'b1);

    // Back-to-back instructions with assorted waits.
    instr(6'b000001, 0, 0, 1'b1, 4);   // ALU zero-wait
    instr(6'b111111, 0, 3, 1'b1, 8);   // STORE, 3 MEM waits
    instr(6'b000110, 2, 0, 1'b1, 6);   // CALL, 2 fetch waits
    instr(6'b111110, 0, 1, 1'b1, 6);   // LOAD, 1 MEM wait
    instr(6'b111101, 0, 0, 1'b1, 4);   // ALU upper encoding
    instr(6'b000100, 0, 0, 1'b0, 4);   // BRANCH, run dropped in EXEC
    cyc(0, 0, 1'b1, 1'b0);             // back in IDLE, busy low

    // NOP class.
    cyc(0, 0, 1'b0, 1'b1);
    instr(6'b000000, 0, 0, 1'b0, 4);
    cyc(0, 0, 1'b0, 1'b1);

    // Reset in the middle of a LOAD's MEM handshake.
    reg_seen = 1'b0;
    opcode   = 6'b111110;
    cyc(1, 4, 1'b1, 1'b1);
    cyc(2, 4, 1'b0, 1'b1);
    cyc(3, 4, 1'b0, 1'b1);
    rst = 1'b1;
    cyc(4, 4, 1'b1, 1'b1);
    rst = 1'b0;
    cyc(0, 0, 1'b0, 1'b0);
    cyc(0, 0, 1'b0, 1'b0);
    check_lit("no_reg_write", int'(reg_seen), 0);

`ifdef SEQ_MEM_TIMEOUT_EN
    // Fetch never acknowledged: ERROR after 16 request cycles, held until rst.
    cyc(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(6, 0, 1'b1, 1'b1);
    rst = 1'b1;
    cyc(6, 0, 1'b1, 1'b1);
    rst = 1'b0;
    cyc(0, 0, 1'b0, 1'b0);
`else
    // Without the timeout, a long fetch wait simply completes.
    cyc(0, 0, 1'b0, 1'b1);
    instr(6'b000010, 20, 0, 1'b0, 24);
    cyc(0, 0, 1'b0, 1'b0);
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
